mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register for the 5-stage integer pipeline; sits directly upstream of the

---
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures MEM results, aligns/extends load data, applies stall/flush.
// Optional MW_BYPASS_EN adds combinational write-back forwarding toward the ID stage.
module mem_wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_m,
  input  logic          reg_write_m,
  input  logic          mem_to_reg_m,
  input  logic          fp_operation_m,
  input  logic [AW-1:0] rd_addr_m,
  input  logic [DW-1:0] alu_out_m,
  input  logic [DW-1:0] mem_rdata_m,
  input  logic [1:0]    load_size_m,
  input  logic          load_unsigned_m,
  output logic          valid_mw,
  output logic          reg_write_mw,
  output logic          mem_to_reg_mw,
  output logic          fp_operation_mw,
  output logic [AW-1:0] rd_addr_mw,
  output logic [DW-1:0] alu_out_mw,
  output logic [DW-1:0] mem_data_to_reg,
  output logic          misalign_mw,
  output logic [31:0]   wb_count
`ifdef MW_BYPASS_EN
  ,
  input  logic [AW-1:0] rs_addr_d,
  input  logic [AW-1:0] rt_addr_d,
  output logic          rs_fwd_hit,
  output logic          rt_fwd_hit,
  output logic [DW-1:0] wb_fwd_data
`endif
);

  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [DW-1:0] ext_s;
  logic [DW-1:0] load_data_s;
  logic          mis_s;
  logic          wb_commit_s;

  // Lane select and extension of the raw little-endian memory word
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    ext_s       = {DW{1'b0}};
    mis_s       = 1'b0;
    load_data_s = {DW{1'b0}};
    case (alu_out_m[1:0])
      2'b00:   byte_s = mem_rdata_m[7:0];
      2'b01:   byte_s = mem_rdata_m[15:8];
      2'b10:   byte_s = mem_rdata_m[23:16];
      2'b11:   byte_s = mem_rdata_m[31:24];
      default: byte_s = 8'h00;
    endcase
    if (alu_out_m[1]) begin
      half_s = mem_rdata_m[31:16];
    end else begin
      half_s = mem_rdata_m[15:0];
    end
    // Reserved size 2'b11 falls into the word path on purpose
    case (load_size_m)
      2'b01: begin
        mis_s = alu_out_m[0];
        if (load_unsigned_m) begin
          ext_s = {{(DW-16){1'b0}}, half_s};
        end else begin
          ext_s = {{(DW-16){half_s[15]}}, half_s};
        end
      end
      2'b10: begin
        mis_s = 1'b0;
        if (load_unsigned_m) begin
          ext_s = {{(DW-8){1'b0}}, byte_s};
        end else begin
          ext_s = {{(DW-8){byte_s[7]}}, byte_s};
        end
      end
      default: begin
        mis_s = (alu_out_m[1:0] != 2'b00);
        ext_s = mem_rdata_m;
      end
    endcase
    if (mem_to_reg_m) begin
      load_data_s = ext_s;
    end else begin
      load_data_s = {DW{1'b0}};
    end
  end

  assign wb_commit_s = reg_write_mw & ~fp_operation_mw & (rd_addr_mw != {AW{1'b0}});

  // Pipeline register with flush > stall > capture; commit counter follows the departing write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_mw        <= 1'b0;
      reg_write_mw    <= 1'b0;
      mem_to_reg_mw   <= 1'b0;
      fp_operation_mw <= 1'b0;
      rd_addr_mw      <= {AW{1'b0}};
      alu_out_mw      <= {DW{1'b0}};
      mem_data_to_reg <= {DW{1'b0}};
      misalign_mw     <= 1'b0;
      wb_count        <= 32'd0;
    end else begin
      if ((flush || !stall) && wb_commit_s) begin
        wb_count <= wb_count + 32'd1;
      end
      if (flush) begin
        valid_mw        <= 1'b0;
        reg_write_mw    <= 1'b0;
        mem_to_reg_mw   <= 1'b0;
        fp_operation_mw <= 1'b0;
        rd_addr_mw      <= {AW{1'b0}};
        alu_out_mw      <= {DW{1'b0}};
        mem_data_to_reg <= {DW{1'b0}};
        misalign_mw     <= 1'b0;
      end else if (!stall) begin
        valid_mw        <= valid_m;
        reg_write_mw    <= reg_write_m & valid_m & ~mis_s;
        mem_to_reg_mw   <= mem_to_reg_m;
        fp_operation_mw <= fp_operation_m;
        rd_addr_mw      <= rd_addr_m;
        alu_out_mw      <= alu_out_m;
        mem_data_to_reg <= load_data_s;
        misalign_mw     <= valid_m & mem_to_reg_m & mis_s;
      end
    end
  end

`ifdef MW_BYPASS_EN
  // Same-cycle RF write/read forwarding toward decode
  always_comb begin
    rs_fwd_hit  = wb_commit_s & (rd_addr_mw == rs_addr_d);
    rt_fwd_hit  = wb_commit_s & (rd_addr_mw == rt_addr_d);
    if (mem_to_reg_mw) begin
      wb_fwd_data = mem_data_to_reg;
    end else begin
      wb_fwd_data = alu_out_mw;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes hand-computed expected MW state,
// a negedge monitor pops and compares.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        fp;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, flush, valid_m, reg_write_m, mem_to_reg_m, fp_operation_m;
  logic [4:0]  rd_addr_m;
  logic [31:0] alu_out_m, mem_rdata_m;
  logic [1:0]  load_size_m;
  logic        load_unsigned_m;
  logic        valid_mw, reg_write_mw, mem_to_reg_mw, fp_operation_mw, misalign_mw;
  logic [4:0]  rd_addr_mw;
  logic [31:0] alu_out_mw, mem_data_to_reg, wb_count;
`ifdef MW_BYPASS_EN
  logic [4:0]  rs_addr_d, rt_addr_d;
  logic        rs_fwd_hit, rt_fwd_hit;
  logic [31:0] wb_fwd_data;
`endif

  int   passed = 0;
  int   total  = 0;
  int   vec_id = 0;
  exp_t exp_q[$];

  mem_wb_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .fp_operation_m(fp_operation_m), .rd_addr_m(rd_addr_m), .alu_out_m(alu_out_m),
    .mem_rdata_m(mem_rdata_m), .load_size_m(load_size_m), .load_unsigned_m(load_unsigned_m),
    .valid_mw(valid_mw), .reg_write_mw(reg_write_mw), .mem_to_reg_mw(mem_to_reg_mw),
    .fp_operation_mw(fp_operation_mw), .rd_addr_mw(rd_addr_mw), .alu_out_mw(alu_out_mw),
    .mem_data_to_reg(mem_data_to_reg), .misalign_mw(misalign_mw), .wb_count(wb_count)
`ifdef MW_BYPASS_EN
    , .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d), .rs_fwd_hit(rs_fwd_hit),
    .rt_fwd_hit(rt_fwd_hit), .wb_fwd_data(wb_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, rw, m2r, fp, mis, input logic [4:0] rd,
                              input logic [31:0] alu, data, cnt);
    exp_t e;
    e.valid = v; e.rw = rw; e.m2r = m2r; e.fp = fp; e.mis = mis;
    e.rd = rd; e.alu = alu; e.data = data; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(valid_mw, reg_write_mw, mem_to_reg_mw, fp_operation_mw, misalign_mw,
              rd_addr_mw, alu_out_mw, mem_data_to_reg, wb_count);
  endfunction

  task automatic check_state(input string name, input exp_t act, input exp_t e);
    total++;
    if (act === e) begin
      passed++;
    end else begin
      $display("FAIL %s: got v=%b rw=%b m2r=%b fp=%b mis=%b rd=%0d alu=%h data=%h cnt=%0d, want v=%b rw=%b m2r=%b fp=%b mis=%b rd=%0d alu=%h data=%h cnt=%0d",
               name, act.valid, act.rw, act.m2r, act.fp, act.mis, act.rd, act.alu, act.data, act.cnt,
               e.valid, e.rw, e.m2r, e.fp, e.mis, e.rd, e.alu, e.data, e.cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act === e) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, want %h", name, act, e);
    end
  endtask

  // Monitor: one expected MW state per elapsed edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vec_id++;
      check_state($sformatf("vec%0d", vec_id), observed(), e);
    end
  end

  task automatic step(input logic v, rw, m2r, fp, input logic [4:0] rd,
                      input logic [31:0] alu, rdata, input logic [1:0] sz,
                      input logic uns, input exp_t e);
    valid_m = v; reg_write_m = rw; mem_to_reg_m = m2r; fp_operation_m = fp;
    rd_addr_m = rd; alu_out_m = alu; mem_rdata_m = rdata;
    load_size_m = sz; load_unsigned_m = uns;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_m = 1'b0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0; fp_operation_m = 1'b0;
    rd_addr_m = 5'd0; alu_out_m = 32'd0; mem_rdata_m = 32'd0;
    load_size_m = 2'b00; load_unsigned_m = 1'b0;
`ifdef MW_BYPASS_EN
    rs_addr_d = 5'd0; rt_addr_d = 5'd0;
`endif
    @(posedge clk);
    exp_q.push_back('0);
    #1;
    @(negedge clk); #2;
    rstn = 1'b1;

    // Capture, then async reset mid-capture with a live write on the inputs
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_0010, 32'h0, 32'd0));
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check_state("reset_immediate", observed(), '0);
    exp_q.push_back('0);
    @(negedge clk); #2;
    rstn = 1'b1;

    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_0020, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h0000_0020, 32'h0, 32'd0));
    // Load extraction
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0103, 32'h80AA_BBCC, 2'b10, 1'b0,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0103, 32'hFFFF_FF80, 32'd1));
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0103, 32'h80AA_BBCC, 2'b10, 1'b1,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0103, 32'h0000_0080, 32'd2));
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0102, 32'h80AA_BBCC, 2'b01, 1'b0,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0102, 32'hFFFF_80AA, 32'd3));
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0101, 32'h80AA_BBCC, 2'b10, 1'b0,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0101, 32'hFFFF_FFBB, 32'd4));
    // Misaligned half, then aligned word
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0101, 32'h80AA_BBCC, 2'b01, 1'b0,
         mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0101, 32'hFFFF_BBCC, 32'd5));
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0104, 32'h80AA_BBCC, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0104, 32'h80AA_BBCC, 32'd5));
    // Stall three cycles with changing inputs: state and count frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'(11 + i), 32'h0000_0030 + 32'(i * 4), 32'h5555_5555, 2'b00, 1'b0,
           mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0104, 32'h80AA_BBCC, 32'd5));
    end
    // Flush overrides stall; departing write still counts
    flush = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 32'h0000_0040, 32'h5555_5555, 2'b00, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd6));
    stall = 1'b0; flush = 1'b0;
    // Back-to-back ALU writes r3, r0, r7, fp r4, r9
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0100, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0100, 32'h0, 32'd6));
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0200, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0200, 32'h0, 32'd7));
`ifdef MW_BYPASS_EN
    rs_addr_d = 5'd7; rt_addr_d = 5'd0;
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_1234, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_1234, 32'h0, 32'd7));
`ifdef MW_BYPASS_EN
    check_val("rs_fwd_hit", {31'd0, rs_fwd_hit}, 32'd1);
    check_val("rt_fwd_hit", {31'd0, rt_fwd_hit}, 32'd0);
    check_val("wb_fwd_data", wb_fwd_data, 32'h0000_1234);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0400, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_0400, 32'h0, 32'd8));
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0500, 32'h0, 2'b00, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_0500, 32'h0, 32'd8));
    // lhu, reserved size as word, invalid instruction
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0100, 32'h1234_F00D, 2'b01, 1'b1,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0100, 32'h0000_F00D, 32'd9));
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0108, 32'h1234_5678, 2'b11, 1'b0,
         mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0000_0108, 32'h1234_5678, 32'd10));
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0000_0010, 32'h0, 2'b00, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h0000_0010, 32'h0, 32'd11));
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd11));

    @(negedge clk); #1;
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
